// File: rtl/pic_8259_pkg.sv
// Shared types and constants for the 8259 PIC interrupt-acknowledge logic.
package pic_8259_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P1   = 3'd1,
    ST_G1   = 3'd2,
    ST_P2   = 3'd3,
    ST_G2   = 3'd4,
    ST_P3   = 3'd5,
    ST_DONE = 3'd6
  } inta_state_t;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  localparam logic [7:0] SPURIOUS_IR = 8'h80;

  // Highest set bit wins, so a malformed multi-hot input still yields a valid IR.
  function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/inta_cycle_sequencer_edge_sync.sv
// Synchronizes the asynchronous INTA# pin and produces one-cycle fall/rise pulses.
module inta_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic pin_n,
  output logic fall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Flops park at 1 (pin idle level) so leaving reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      sync_q <= '1;
      last_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_n};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall = last_q & ~sync_q[SYNC_STAGES-1];
  assign rise = ~last_q & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/inta_cycle_sequencer.sv
// Clocked INTA cycle sequencer: counts acknowledge pulses, drives ISR/IRR strobes,
// cascade ID and the CALL/vector bytes, and issues automatic EOI at the end.
module inta_cycle_sequencer
  import pic_8259_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       interrupt_acknowledge_n,
  input  logic       icw1_write,
  input  logic       mode_8086,
  input  logic       call_interval_4,
  input  logic       auto_eoi,
  input  logic       single_mode,
  input  logic       slave_mode,
  input  logic [7:0] cascade_config,
  input  logic [7:0] vector_base,
  input  logic [2:0] address_low,
  input  logic [2:0] cascade_in,
  input  logic [7:0] interrupt,
  output logic       freeze,
  output logic       latch_in_service,
  output logic [7:0] acknowledge_interrupt,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] cascade_out,
  output logic       cascade_drive,
  output logic [7:0] data_out,
  output logic       data_out_enable
);

  logic fall, rise;

  inta_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (icw1_write),
    .pin_n   (interrupt_acknowledge_n),
    .fall    (fall),
    .rise    (rise)
  );

  inta_state_t state;

  // Per-cycle snapshot of the mode inputs, taken on entry to P1.
  logic       mode_8086_q;
  logic       interval_4_q;
  logic       auto_eoi_q;
  logic       own_q;
  logic       isr_latched_q;
  logic [7:0] vector_base_q;
  logic [2:0] address_low_q;
  logic [2:0] index_q;

  logic [7:0] entry_ack;
  logic [2:0] entry_index;
  logic       cascade_hit;
  logic       entry_cascade_master;
  logic       entry_own;
  logic       cycle_end;
  logic [7:0] second_byte;

  always_comb begin
    entry_ack            = (interrupt != 8'h00) ? interrupt : SPURIOUS_IR;
    entry_index          = onehot_to_index(entry_ack);
    cascade_hit          = |(cascade_config & entry_ack);
    entry_cascade_master = ~slave_mode & ~single_mode & cascade_hit;
    entry_own            = single_mode
                         | (~slave_mode & ~cascade_hit)
                         | (slave_mode & (cascade_in == cascade_config[2:0]));
    cycle_end            = rise & (((state == ST_P2) & mode_8086_q) | (state == ST_P3));
    if (mode_8086_q)
      second_byte = {vector_base_q[7:3], index_q};
    else if (interval_4_q)
      second_byte = {address_low_q, index_q, 2'b00};
    else
      second_byte = {address_low_q[2:1], index_q, 3'b000};
  end

  always_ff @(posedge clock) begin
    if (!reset_n || icw1_write) begin
      state                   <= ST_IDLE;
      freeze                  <= 1'b0;
      latch_in_service        <= 1'b0;
      acknowledge_interrupt   <= 8'h00;
      clear_interrupt_request <= 8'h00;
      end_of_interrupt        <= 8'h00;
      cascade_out             <= 3'd0;
      cascade_drive           <= 1'b0;
      data_out                <= 8'h00;
      data_out_enable         <= 1'b0;
      mode_8086_q             <= 1'b0;
      interval_4_q            <= 1'b0;
      auto_eoi_q              <= 1'b0;
      own_q                   <= 1'b0;
      isr_latched_q           <= 1'b0;
      vector_base_q           <= 8'h00;
      address_low_q           <= 3'd0;
      index_q                 <= 3'd0;
    end else begin
      latch_in_service        <= 1'b0;
      clear_interrupt_request <= 8'h00;
      end_of_interrupt        <= 8'h00;

      case (state)
        // DONE shares IDLE's entry path so a fall arriving in DONE is not dropped.
        ST_IDLE, ST_DONE: begin
          if (fall) begin
            state                   <= ST_P1;
            acknowledge_interrupt   <= entry_ack;
            freeze                  <= 1'b1;
            latch_in_service        <= (interrupt != 8'h00);
            clear_interrupt_request <= entry_ack;
            cascade_out             <= entry_cascade_master ? entry_index : 3'd0;
            cascade_drive           <= entry_cascade_master;
            data_out                <= mode_8086 ? 8'h00 : CALL_OPCODE;
            data_out_enable         <= ~mode_8086 & (entry_own | ~slave_mode);
            mode_8086_q             <= mode_8086;
            interval_4_q            <= call_interval_4;
            auto_eoi_q              <= auto_eoi;
            own_q                   <= entry_own;
            isr_latched_q           <= (interrupt != 8'h00);
            vector_base_q           <= vector_base;
            address_low_q           <= address_low;
            index_q                 <= entry_index;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_P1: begin
          if (rise) begin
            state           <= ST_G1;
            data_out        <= 8'h00;
            data_out_enable <= 1'b0;
          end
        end
        ST_G1: begin
          if (fall) begin
            state           <= ST_P2;
            data_out        <= second_byte;
            data_out_enable <= own_q;
          end
        end
        ST_P2: begin
          if (rise) begin
            state           <= ST_G2;
            data_out        <= 8'h00;
            data_out_enable <= 1'b0;
          end
        end
        ST_G2: begin
          if (fall) begin
            state           <= ST_P3;
            data_out        <= vector_base_q;
            data_out_enable <= own_q;
          end
        end
        ST_P3: ;
        default: state <= ST_IDLE;
      endcase

      // Final rising edge of the cycle: release everything and issue AEOI.
      if (cycle_end) begin
        state                 <= ST_DONE;
        freeze                <= 1'b0;
        cascade_drive         <= 1'b0;
        cascade_out           <= 3'd0;
        acknowledge_interrupt <= 8'h00;
        data_out              <= 8'h00;
        data_out_enable       <= 1'b0;
        end_of_interrupt      <= (auto_eoi_q & isr_latched_q) ? acknowledge_interrupt : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_inta_cycle_sequencer.sv
// Bench for inta_cycle_sequencer: table of known INTA cycles, random cycles against
// a transaction-level model, and hand sequences for abort/reset/latency corners.
module tb_inta_cycle_sequencer;

  localparam int SYNC_STAGES = 2;

  logic       clock;
  logic       reset_n;
  logic       interrupt_acknowledge_n;
  logic       icw1_write;
  logic       mode_8086;
  logic       call_interval_4;
  logic       auto_eoi;
  logic       single_mode;
  logic       slave_mode;
  logic [7:0] cascade_config;
  logic [7:0] vector_base;
  logic [2:0] address_low;
  logic [2:0] cascade_in;
  logic [7:0] interrupt;
  logic       freeze;
  logic       latch_in_service;
  logic [7:0] acknowledge_interrupt;
  logic [7:0] clear_interrupt_request;
  logic [7:0] end_of_interrupt;
  logic [2:0] cascade_out;
  logic       cascade_drive;
  logic [7:0] data_out;
  logic       data_out_enable;

  inta_cycle_sequencer #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .icw1_write              (icw1_write),
    .mode_8086               (mode_8086),
    .call_interval_4         (call_interval_4),
    .auto_eoi                (auto_eoi),
    .single_mode             (single_mode),
    .slave_mode              (slave_mode),
    .cascade_config          (cascade_config),
    .vector_base             (vector_base),
    .address_low             (address_low),
    .cascade_in              (cascade_in),
    .interrupt               (interrupt),
    .freeze                  (freeze),
    .latch_in_service        (latch_in_service),
    .acknowledge_interrupt   (acknowledge_interrupt),
    .clear_interrupt_request (clear_interrupt_request),
    .end_of_interrupt        (end_of_interrupt),
    .cascade_out             (cascade_out),
    .cascade_drive           (cascade_drive),
    .data_out                (data_out),
    .data_out_enable         (data_out_enable)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       m8086, ci4, aeoi, sngl, slave;
    logic [7:0] ccfg, vb;
    logic [2:0] al, cin;
    logic [7:0] irq;
    logic [7:0] ack;
    logic       latch;
    logic [7:0] eoi;
    logic       cas_drv;
    logic [2:0] cas;
    logic [2:0] en;      // bit p = byte of pulse p+1 driven
    logic [7:0] b0, b1, b2;
  } vec_t;

  int         n_vec = 0;
  int         n_bad = 0;
  int         lis_cnt, clr_cnt, eoi_cnt;
  logic [7:0] clr_val, eoi_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n clocks, sampling 1ns after each edge and tallying strobes.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (latch_in_service) lis_cnt++;
      if (clear_interrupt_request != 8'h00) begin
        clr_cnt++;
        clr_val = clear_interrupt_request;
      end
      if (end_of_interrupt != 8'h00) begin
        eoi_cnt++;
        eoi_val = end_of_interrupt;
      end
    end
  endtask

  task automatic clear_tally();
    lis_cnt = 0; clr_cnt = 0; eoi_cnt = 0; clr_val = 8'h00; eoi_val = 8'h00;
  endtask

  task automatic apply_cfg(input vec_t v);
    mode_8086 = v.m8086; call_interval_4 = v.ci4; auto_eoi = v.aeoi;
    single_mode = v.sngl; slave_mode = v.slave; cascade_config = v.ccfg;
    vector_base = v.vb; address_low = v.al; cascade_in = v.cin; interrupt = v.irq;
  endtask

  function automatic logic [31:0] all_outputs();
    return {8'h00, freeze, latch_in_service, cascade_drive, data_out_enable, cascade_out,
            1'b0, acknowledge_interrupt | clear_interrupt_request | end_of_interrupt | data_out};
  endfunction

  function automatic vec_t mkv(input logic m8086, ci4, aeoi, sngl, slave,
                               input logic [7:0] ccfg, vb, input logic [2:0] al, cin,
                               input logic [7:0] irq, ack, input logic latch,
                               input logic [7:0] eoi, input logic cas_drv,
                               input logic [2:0] cas, en, input logic [7:0] b0, b1, b2);
    vec_t v;
    v.m8086 = m8086; v.ci4 = ci4; v.aeoi = aeoi; v.sngl = sngl; v.slave = slave;
    v.ccfg = ccfg; v.vb = vb; v.al = al; v.cin = cin; v.irq = irq;
    v.ack = ack; v.latch = latch; v.eoi = eoi; v.cas_drv = cas_drv; v.cas = cas;
    v.en = en; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  // Reference model: what the CPU should observe for one whole INTA cycle.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   idx;
    logic cas_master, owner;
    r = v;
    r.ack = (v.irq == 8'h00) ? 8'h80 : v.irq;
    idx = 0;
    for (int i = 0; i < 8; i++) if (r.ack[i]) idx = i;
    r.latch = (v.irq != 8'h00);
    r.eoi = (v.aeoi && r.latch) ? r.ack : 8'h00;
    cas_master = !v.slave && !v.sngl && ((v.ccfg & r.ack) != 8'h00);
    r.cas_drv = cas_master;
    r.cas = cas_master ? 3'(idx) : 3'd0;
    if (v.sngl) owner = 1'b1;
    else if (v.slave) owner = (v.cin == v.ccfg[2:0]);
    else owner = !cas_master;
    r.b0 = 8'h00; r.b1 = 8'h00; r.b2 = 8'h00;
    if (v.m8086) begin
      r.b1 = 8'((v.vb / 8) * 8 + idx);
      r.en = {1'b0, owner, 1'b0};
    end else begin
      r.b0 = 8'hCD;
      r.b1 = v.ci4 ? 8'(v.al * 32 + idx * 4) : 8'((v.al / 2) * 64 + idx * 8);
      r.b2 = v.vb;
      r.en = {owner, owner, owner || !v.slave};
    end
    return r;
  endfunction

  // Driver: full INTA cycle with comfortably long low/high phases, then checks.
  task automatic run_txn(input vec_t v, input string tag);
    int         np;
    logic [7:0] exp_b;
    apply_cfg(v);
    interrupt_acknowledge_n = 1'b1;
    step(2);
    clear_tally();
    np = v.m8086 ? 2 : 3;
    for (int p = 0; p < np; p++) begin
      interrupt_acknowledge_n = 1'b0;
      step(6);
      if (p == 0) begin
        check($sformatf("%s ack", tag), 32'(acknowledge_interrupt), 32'(v.ack));
        check($sformatf("%s cas_drive", tag), 32'(cascade_drive), 32'(v.cas_drv));
        if (v.cas_drv) check($sformatf("%s cas_out", tag), 32'(cascade_out), 32'(v.cas));
      end
      check($sformatf("%s freeze p%0d", tag, p + 1), 32'(freeze), 32'd1);
      check($sformatf("%s en p%0d", tag, p + 1), 32'(data_out_enable), 32'(v.en[p]));
      exp_b = (p == 0) ? v.b0 : (p == 1) ? v.b1 : v.b2;
      if (v.en[p]) check($sformatf("%s byte p%0d", tag, p + 1), 32'(data_out), 32'(exp_b));
      interrupt_acknowledge_n = 1'b1;
      step(6);
      check($sformatf("%s gap en p%0d", tag, p + 1), 32'(data_out_enable), 32'd0);
    end
    check($sformatf("%s end freeze", tag), 32'(freeze), 32'd0);
    check($sformatf("%s end ack", tag), 32'(acknowledge_interrupt), 32'd0);
    check($sformatf("%s end cas_drive", tag), 32'(cascade_drive), 32'd0);
    check($sformatf("%s lis count", tag), 32'(lis_cnt), 32'(v.latch));
    check($sformatf("%s clr count", tag), 32'(clr_cnt), 32'd1);
    check($sformatf("%s clr value", tag), 32'(clr_val), 32'(v.ack));
    check($sformatf("%s eoi count", tag), 32'(eoi_cnt), (v.eoi != 8'h00) ? 32'd1 : 32'd0);
    if (v.eoi != 8'h00) check($sformatf("%s eoi value", tag), 32'(eoi_val), 32'(v.eoi));
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    //               86 i4 ae sg sl ccfg   vb     al    cin   irq  | ack   lis eoi  cd cas  en      b0     b1     b2
    tbl[0] = mkv(1, 0, 0, 1, 0, 8'h00, 8'h40, 3'd0, 3'd0, 8'h08, 8'h08, 1, 8'h00, 0, 3'd0, 3'b010, 8'h00, 8'h43, 8'h00);
    tbl[1] = mkv(0, 1, 0, 0, 0, 8'h00, 8'h12, 3'd5, 3'd0, 8'h20, 8'h20, 1, 8'h00, 0, 3'd0, 3'b111, 8'hCD, 8'hB4, 8'h12);
    tbl[2] = mkv(1, 0, 0, 0, 0, 8'h04, 8'h40, 3'd0, 3'd0, 8'h04, 8'h04, 1, 8'h00, 1, 3'd2, 3'b000, 8'h00, 8'h00, 8'h00);
    tbl[3] = mkv(1, 0, 0, 0, 1, 8'h03, 8'h48, 3'd0, 3'd3, 8'h02, 8'h02, 1, 8'h00, 0, 3'd0, 3'b010, 8'h00, 8'h49, 8'h00);
    tbl[4] = mkv(1, 0, 0, 0, 1, 8'h03, 8'h48, 3'd0, 3'd5, 8'h02, 8'h02, 1, 8'h00, 0, 3'd0, 3'b000, 8'h00, 8'h00, 8'h00);
    tbl[5] = mkv(1, 0, 1, 1, 0, 8'h00, 8'h40, 3'd0, 3'd0, 8'h00, 8'h80, 0, 8'h00, 0, 3'd0, 3'b010, 8'h00, 8'h47, 8'h00);
    tbl[6] = mkv(1, 0, 1, 1, 0, 8'h00, 8'h20, 3'd0, 3'd0, 8'h10, 8'h10, 1, 8'h10, 0, 3'd0, 3'b010, 8'h00, 8'h24, 8'h00);
    tbl[7] = mkv(0, 0, 0, 1, 0, 8'h00, 8'hAB, 3'd6, 3'd0, 8'h02, 8'h02, 1, 8'h00, 0, 3'd0, 3'b111, 8'hCD, 8'hC8, 8'hAB);
    tbl[8] = mkv(0, 1, 0, 0, 0, 8'h02, 8'h12, 3'd0, 3'd0, 8'h02, 8'h02, 1, 8'h00, 1, 3'd1, 3'b001, 8'hCD, 8'h00, 8'h00);
    tbl[9] = mkv(0, 1, 1, 0, 1, 8'h05, 8'h77, 3'd0, 3'd2, 8'h01, 8'h01, 1, 8'h01, 0, 3'd0, 3'b000, 8'h00, 8'h00, 8'h00);

    reset_n = 1'b0;
    icw1_write = 1'b0;
    interrupt_acknowledge_n = 1'b1;
    apply_cfg(tbl[0]);
    clear_tally();
    step(3);
    check("reset outputs", all_outputs(), 32'd0);
    reset_n = 1'b1;
    step(2);

    for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Fall-to-P1 latency is SYNC_STAGES+1 clocks.
    apply_cfg(tbl[0]);
    interrupt_acknowledge_n = 1'b0;
    step(SYNC_STAGES);
    check("latency early freeze", 32'(freeze), 32'd0);
    step(1);
    check("latency freeze", 32'(freeze), 32'd1);
    step(3);
    interrupt_acknowledge_n = 1'b1; step(6);
    interrupt_acknowledge_n = 1'b0; step(6);
    interrupt_acknowledge_n = 1'b1; step(6);

    // icw1_write during G1 of a cascaded cycle aborts everything.
    apply_cfg(tbl[2]);
    interrupt_acknowledge_n = 1'b0; step(6);
    interrupt_acknowledge_n = 1'b1; step(6);
    check("abort pre cas_drive", 32'(cascade_drive), 32'd1);
    icw1_write = 1'b1;
    step(1);
    icw1_write = 1'b0;
    check("abort outputs", all_outputs(), 32'd0);
    step(4);
    check("abort stays idle", 32'(freeze), 32'd0);

    // Reset low in the middle of P2.
    apply_cfg(tbl[0]);
    interrupt_acknowledge_n = 1'b0; step(6);
    interrupt_acknowledge_n = 1'b1; step(6);
    interrupt_acknowledge_n = 1'b0; step(6);
    check("midp2 enable", 32'(data_out_enable), 32'd1);
    reset_n = 1'b0;
    interrupt_acknowledge_n = 1'b1;
    step(1);
    check("midp2 reset outputs", all_outputs(), 32'd0);
    reset_n = 1'b1;
    step(4);
    check("midp2 stays idle", 32'(freeze), 32'd0);

    // A new fall arriving during DONE starts the next cycle immediately.
    apply_cfg(mkv(1, 0, 1, 1, 0, 8'h00, 8'h08, 3'd0, 3'd0, 8'h01, 8'h01, 1, 8'h01, 0, 3'd0, 3'b010, 8'h00, 8'h08, 8'h00));
    clear_tally();
    interrupt_acknowledge_n = 1'b0; step(6);
    interrupt_acknowledge_n = 1'b1; step(6);
    interrupt_acknowledge_n = 1'b0; step(6);
    interrupt_acknowledge_n = 1'b1; step(1);
    interrupt_acknowledge_n = 1'b0; step(6);
    check("done-fall eoi count", 32'(eoi_cnt), 32'd1);
    check("done-fall eoi value", 32'(eoi_val), 32'h01);
    check("done-fall freeze", 32'(freeze), 32'd1);
    check("done-fall ack", 32'(acknowledge_interrupt), 32'h01);
    check("done-fall lis count", 32'(lis_cnt), 32'd2);
    interrupt_acknowledge_n = 1'b1; step(6);
    interrupt_acknowledge_n = 1'b0; step(6);
    interrupt_acknowledge_n = 1'b1; step(6);
    check("done-fall final freeze", 32'(freeze), 32'd0);

    // Randomized cycles against the model.
    for (int i = 0; i < 40; i++) begin
      rv.m8086 = 1'($urandom_range(0, 1));
      rv.ci4   = 1'($urandom_range(0, 1));
      rv.aeoi  = 1'($urandom_range(0, 1));
      rv.sngl  = ($urandom_range(0, 3) == 0);
      rv.slave = 1'($urandom_range(0, 1));
      rv.ccfg  = 8'($urandom_range(0, 255));
      rv.vb    = 8'($urandom_range(0, 255));
      rv.al    = 3'($urandom_range(0, 7));
      rv.cin   = ($urandom_range(0, 1) == 1) ? rv.ccfg[2:0] : 3'($urandom_range(0, 7));
      rv.irq   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      run_txn(model(rv), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
